// File: rtl/hdmi_reconf_sequencer_pkg.sv
// hdmi_reconf_sequencer_pkg: shared state encoding and sequencing constants.
package hdmi_reconf_sequencer_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DRAIN     = 3'd1,
    LOAD      = 3'd2,
    APPLY     = 3'd3,
    LOCK_WAIT = 3'd4,
    RELEASE   = 3'd5
  } state_t;
  localparam int RECONF_MAX_RETRIES = 3;
  localparam int BUSY_WAIT = 2;
endpackage

// File: rtl/hdmi_reconf_sequencer_if.sv
// hdmi_reconf_sequencer_if: mode request handshake between the i2c request path and the sequencer.
interface hdmi_reconf_sequencer_if;
  logic [7:0] mode_req;
  logic       mode_req_valid;
  logic       mode_req_ready;
  modport master (output mode_req, mode_req_valid, input mode_req_ready);
  modport slave (input mode_req, mode_req_valid, output mode_req_ready);
endinterface

// File: rtl/hdmi_reconf_sequencer_cycle_counter.sv
// hdmi_reconf_sequencer_cycle_counter: saturating counter; tc flags that the count reaches LIMIT this cycle.
module hdmi_reconf_sequencer_cycle_counter #(
  parameter int LIMIT = 2
) (
  input  logic clock,
  input  logic nreset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] count;
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) count <= '0;
    else if (clr) count <= '0;
    else if (en && count != W'(LIMIT)) count <= count + 1'b1;
  end
  // tc ignores clr so it can feed next-state logic that itself drives clr
  assign tc = count == W'(LIMIT) || (en && count == W'(LIMIT - 1));
endmodule

// File: rtl/hdmi_reconf_sequencer.sv
// hdmi_reconf_sequencer: holds the HDMI pipeline, reloads the PLL from ROM and releases after stable lock.
// Define RECONF_SEQ_RETRY_EN to retry reconfiguration on lock timeout instead of failing at once.
module hdmi_reconf_sequencer
  import hdmi_reconf_sequencer_pkg::*;
#(
  parameter int DRAIN_CYCLES  = 64,
  parameter int SETTLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 5400000
) (
  input  logic                   clock,
  input  logic                   nreset,
  hdmi_reconf_sequencer_if.slave req,
  input  logic                   reconf_busy,
  output logic                   write_from_rom,
  output logic                   reconfig,
  output logic [7:0]             rom_select,
  input  logic                   pll_locked,
  output logic                   video_hold,
  output logic                   done,
  output logic                   error,
  output logic [2:0]             state_dbg
);
  state_t state, next;
  logic cfg_valid, accept, same_mode, retry, fail, wfr_d, reconfig_d;
  logic drain_tc, elapsed_tc, settle_tc, timeout_tc;
  assign req.mode_req_ready = state == IDLE;
  assign accept = req.mode_req_valid && req.mode_req_ready;
  assign same_mode = req.mode_req == rom_select && cfg_valid && pll_locked;
  assign state_dbg = state;
  hdmi_reconf_sequencer_cycle_counter #(.LIMIT(DRAIN_CYCLES)) u_drain (
    .clock, .nreset, .clr(state != DRAIN), .en(1'b1), .tc(drain_tc));
  hdmi_reconf_sequencer_cycle_counter #(.LIMIT(BUSY_WAIT)) u_elapsed (
    .clock, .nreset, .clr(state != next || !(state inside {LOAD, APPLY})), .en(1'b1), .tc(elapsed_tc));
  hdmi_reconf_sequencer_cycle_counter #(.LIMIT(SETTLE_CYCLES)) u_settle (
    .clock, .nreset, .clr(state != LOCK_WAIT || !pll_locked), .en(pll_locked), .tc(settle_tc));
  hdmi_reconf_sequencer_cycle_counter #(.LIMIT(LOCK_TIMEOUT)) u_timeout (
    .clock, .nreset, .clr(state != LOCK_WAIT), .en(1'b1), .tc(timeout_tc));
`ifdef RECONF_SEQ_RETRY_EN
  logic [1:0] retries;
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) retries <= '0;
    else if (accept) retries <= '0;
    else if (state == LOCK_WAIT && next == DRAIN) retries <= retries + 2'd1;
  end
  assign retry = retries != 2'(RECONF_MAX_RETRIES);
`else
  assign retry = 1'b0;
`endif
  always_comb begin
    next = state;
    wfr_d = 1'b0;
    reconfig_d = 1'b0;
    fail = 1'b0;
    case (state)
      IDLE: next = accept ? (same_mode ? RELEASE : DRAIN) : (cfg_valid && !pll_locked) ? LOCK_WAIT : IDLE;
      DRAIN: begin
        next = drain_tc ? LOAD : DRAIN;
        wfr_d = drain_tc;
      end
      LOAD: begin
        reconfig_d = elapsed_tc && !reconf_busy;
        next = reconfig_d ? APPLY : LOAD;
      end
      APPLY: next = (elapsed_tc && !reconf_busy) ? LOCK_WAIT : APPLY;
      LOCK_WAIT: begin
        fail = !settle_tc && timeout_tc && !retry;
        next = settle_tc ? RELEASE : !timeout_tc ? LOCK_WAIT : retry ? DRAIN : RELEASE;
      end
      RELEASE: next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else state <= next;
  end
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      rom_select <= 8'h00;
      cfg_valid <= 1'b0;
      video_hold <= 1'b1;
      write_from_rom <= 1'b0;
      reconfig <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      write_from_rom <= wfr_d;
      reconfig <= reconfig_d;
      done <= state == RELEASE;
      if (accept) rom_select <= req.mode_req;
      error <= accept ? 1'b0 : error | fail;
      cfg_valid <= (state == LOCK_WAIT && settle_tc) ? 1'b1 : (next == DRAIN || next == LOCK_WAIT) ? 1'b0 : cfg_valid;
      video_hold <= state == RELEASE ? 1'b0 : (next == DRAIN || next == LOCK_WAIT) ? 1'b1 : video_hold;
    end
  end
endmodule

// File: doc/hdmi_reconf_sequencer.md
# hdmi_reconf_sequencer

Sequences a mode change of the HDMI output path. On a mode request it holds the HDMI-clock video pipeline (ram2video and ADV7513 startup) in reset, loads the selected PLL configuration from ROM into the PLL reconfiguration controller, and triggers reconfiguration. It then waits for stable PLL lock and releases the pipeline. It sits between the i2c-driven reconf request path and `pll_hdmi_reconf`/`reconf_rom`, and runs in the 54 MHz domain.

## Interface
Parameters:
- DRAIN_CYCLES, 64: cycles `video_hold` is asserted before the PLL is touched.
- SETTLE_CYCLES, 1024: consecutive `pll_locked` cycles required before release.
- LOCK_TIMEOUT, 5400000: cycles allowed for lock (100 ms at 54 MHz).

Ports:
- clock  in  1  54 MHz system clock
- nreset  in  1  asynchronous, active-low reset
- mode_req  in  8  requested PLL configuration code
- mode_req_valid  in  1  request present
- mode_req_ready  out  1  request accepted when valid && ready
- reconf_busy  in  1  busy from PLL reconfig controller
- write_from_rom  out  1  one-cycle pulse: load ROM image
- reconfig  out  1  one-cycle pulse: apply config to PLL
- rom_select  out  8  latched mode code driving ROM base select
- pll_locked  in  1  HDMI PLL lock (already synchronised)
- video_hold  out  1  holds HDMI pipeline startup in reset
- done  out  1  one-cycle pulse on release
- error  out  1  sticky lock-timeout flag, cleared by next accepted request
- state_dbg  out  3  current state encoding for debugData

## Operation
- States: IDLE(0), DRAIN(1), LOAD(2), APPLY(3), LOCK_WAIT(4), RELEASE(5).
- IDLE: `mode_req_ready` = (state==IDLE), combinational. Accepting a request latches `rom_select` and clears `error`.
  - If `mode_req` equals the current `rom_select`, `cfg_valid`=1 and `pll_locked`=1: the PLL is left untouched and the FSM goes directly to RELEASE.
  - Otherwise: go to DRAIN.
- DRAIN: assert `video_hold`; count DRAIN_CYCLES; then pulse `write_from_rom` and go to LOAD.
- LOAD: wait until 2 cycles have elapsed since the pulse and `reconf_busy`=0; then pulse `reconfig` and go to APPLY.
- APPLY: same busy rule as LOAD; then clear the settle/timeout counters and go to LOCK_WAIT.
- LOCK_WAIT: the settle counter increments while `pll_locked`=1 and resets to 0 when it drops.
  - Settle counter reaches SETTLE_CYCLES: set `cfg_valid`, go to RELEASE.
  - Timeout counter reaches LOCK_TIMEOUT first: timeout handling per Configuration.
- RELEASE: deassert `video_hold`, pulse `done`, go to IDLE.
- Lock loss in IDLE (falling `pll_locked` while `cfg_valid`=1): assert `video_hold` and enter LOCK_WAIT with cleared counters. `mode_req_ready` is low throughout.
- A request arriving in any non-IDLE state is not accepted and is held by the producer.
- Counters are sized $clog2(param+1) and saturate. There is no wrap-around.

## Timing
- Reset values:
  - state=IDLE, `rom_select`=8'h00, `cfg_valid`=0
  - `video_hold`=1
  - `write_from_rom`=0, `reconfig`=0, `done`=0, `error`=0
  - `state_dbg`=0
- `mode_req_ready`=1 during reset. The first request always reconfigures because `cfg_valid`=0.
- All outputs except `mode_req_ready` are registered and change 1 cycle after the state transition.
- Accept to first `write_from_rom` pulse: DRAIN_CYCLES+1 cycles.
- Same-mode accept to `done`: 2 cycles.
- Reset mid-operation returns to IDLE immediately, with `video_hold`=1 and outputs at reset values.
- A lock drop in the same cycle as the settle terminal count: the drop wins and the counter resets.

## Configuration
- RECONF_SEQ_RETRY_EN defined: on timeout, up to 3 retries are made by re-entering DRAIN (`video_hold` stays 1). The retry counter clears on accept. After the 3rd failed retry: set `error`, go to RELEASE.
- Not defined: on the first timeout, set `error` and go to RELEASE (pipeline released unlocked, `cfg_valid` stays 0).

## Structure
- Shared package: state enum typedef and `RECONF_MAX_RETRIES`=3.
- One sub-module, `cycle_counter` (saturating counter with clear/enable/terminal-count), instantiated for drain, settle, timeout and the busy-elapsed count.

## Test plan
- Reset, request 8'h02 → `video_hold` held; `write_from_rom` pulse 65 cycles after accept; `reconfig` pulse after busy drops; `done` once `pll_locked` has been high 1024 cycles; `rom_select`=8'h02.
- Repeat request 8'h02 while locked → `done` 2 cycles after accept, with no `write_from_rom` or `reconfig` pulses.
- `pll_locked` glitches low at settle count 1000 → counter restarts; `done` arrives 1024 cycles after the glitch ends.
- `pll_locked` never asserts (LOCK_TIMEOUT=1000):
  - With RETRY_EN: 4 `reconfig` pulses, then `error`=1 and `done`.
  - Without: 1 pulse, then `error`=1.
- `pll_locked` falls in IDLE → `video_hold` rises next cycle, `mode_req_ready`=0, recovers after 1024 locked cycles.
- Assert `nreset` in LOAD → state_dbg=0, `video_hold`=1, no pulses; next request restarts cleanly.
